// File: rtl/data_mem_pkg.sv
// Shared definitions for the RV32I data memory: access-width encodings and
// the misaligned-access predicate used when DATA_MEM_ALIGN_CHECK_EN is defined.
package data_mem_pkg;

    typedef enum logic [1:0] {
        WIDTH_BYTE = 2'b00,
        WIDTH_HALF = 2'b01,
        WIDTH_WORD = 2'b10,
        WIDTH_RSVD = 2'b11
    } width_e;

    // Halfword needs a[0]=0, word needs a[1:0]=0; the reserved width never aligns.
    function automatic logic is_misaligned(input width_e width, input logic [1:0] addr_lo);
        logic mis;
        case (width)
            WIDTH_BYTE: mis = 1'b0;
            WIDTH_HALF: mis = addr_lo[0];
            WIDTH_WORD: mis = (addr_lo != 2'b00);
            default:    mis = 1'b1;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational load formatter: picks the byte/halfword/word from a raw
// little-endian 32-bit value and sign- or zero-extends it. Reserved width yields 0.
module load_extend
    import data_mem_pkg::*;
(
    input  logic [31:0] raw,
    input  width_e      width,
    input  logic        signext,
    output logic [31:0] result
);

    // Select the accessed lanes and extend to 32 bits
    always_comb begin
        result = '0;
        case (width)
            WIDTH_BYTE: result = {{24{signext & raw[7]}}, raw[7:0]};
            WIDTH_HALF: result = {{16{signext & raw[15]}}, raw[15:0]};
            WIDTH_WORD: result = raw;
            default:    result = '0;
        endcase
    end

endmodule

// File: rtl/data_mem_rv32.sv
// Byte-addressed little-endian data memory for the RV32I MEM stage.
// Synchronous writes, registered reads (read-before-write on a shared address),
// address wrap-around modulo DEPTH_BYTES. Contents survive RST.
// Optional feature: define DATA_MEM_ALIGN_CHECK_EN to add the registered
// misalign_err output and suppress misaligned/reserved accesses.
module data_mem_rv32
    import data_mem_pkg::*;
#(
    parameter int unsigned DEPTH_BYTES = 1024  // power of two, >= 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        data_i,
    input  logic        data_o,
    input  logic [1:0]  data_width,
    input  logic [31:0] data_addr,
    input  logic        signext,
    input  logic [31:0] input_data,
    output logic [31:0] read
`ifdef DATA_MEM_ALIGN_CHECK_EN
    ,
    output logic        misalign_err
`endif
);

    localparam int unsigned ADDR_W = $clog2(DEPTH_BYTES);

    logic [7:0] mem [DEPTH_BYTES];

    width_e            width;
    logic [ADDR_W-1:0] a0, a1, a2, a3;
    logic [31:0]       raw_word;
    logic [31:0]       load_val;
    logic              store_ok;
    logic              load_ok;
    logic              unused_addr_hi;

    assign width = width_e'(data_width);

    // Lane addresses wrap naturally in ADDR_W bits; upper address bits are ignored.
    assign a0 = data_addr[ADDR_W-1:0];
    assign a1 = a0 + ADDR_W'(1);
    assign a2 = a0 + ADDR_W'(2);
    assign a3 = a0 + ADDR_W'(3);
    assign unused_addr_hi = ^data_addr[31:ADDR_W];

    assign raw_word = {mem[a3], mem[a2], mem[a1], mem[a0]};

`ifdef DATA_MEM_ALIGN_CHECK_EN
    logic misaligned;
    assign misaligned = is_misaligned(width, data_addr[1:0]);
    assign store_ok   = !misaligned;
    assign load_ok    = !misaligned;
`else
    assign store_ok = (width != WIDTH_RSVD);
    assign load_ok  = 1'b1;  // reserved width already formats to 0
`endif

    load_extend u_load_extend (
        .raw     (raw_word),
        .width   (width),
        .signext (signext),
        .result  (load_val)
    );

    // Byte-lane writes; an X enable falls to the not-taken branch, i.e. no access
    always_ff @(posedge CLK) begin
        if (!RST && data_i && store_ok) begin
            mem[a0] <= input_data[7:0];
            if (width == WIDTH_HALF || width == WIDTH_WORD) begin
                mem[a1] <= input_data[15:8];
            end
            if (width == WIDTH_WORD) begin
                mem[a2] <= input_data[23:16];
                mem[a3] <= input_data[31:24];
            end
        end
    end

    // Load result register; samples pre-write contents so same-edge stores are not seen
    always_ff @(posedge CLK) begin
        if (RST) begin
            read <= '0;
        end else if (data_o) begin
            read <= load_ok ? load_val : 32'h0;
        end
    end

`ifdef DATA_MEM_ALIGN_CHECK_EN
    // One-cycle flag for any misaligned or reserved-width access attempt
    always_ff @(posedge CLK) begin
        if (RST) begin
            misalign_err <= 1'b0;
        end else begin
            misalign_err <= (data_i | data_o) & misaligned;
        end
    end
`endif

endmodule

// File: tb/tb_data_mem_rv32.sv
// Self-checking bench for data_mem_rv32 (default build): directed cases with
// constant expectations, then randomized traffic checked against a byte-array model.
module tb_data_mem_rv32;

    localparam int unsigned DEPTH = 1024;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        data_i = 1'b0;
    logic        data_o = 1'b0;
    logic [1:0]  data_width = 2'b00;
    logic [31:0] data_addr = '0;
    logic        signext = 1'b0;
    logic [31:0] input_data = '0;
    logic [31:0] read;
`ifdef DATA_MEM_ALIGN_CHECK_EN
    logic        misalign_err;
`endif

    int total = 0;
    int bad = 0;

    logic [7:0]  mdl [DEPTH];
    logic [31:0] exp_read = '0;

    always #5 CLK = ~CLK;

    data_mem_rv32 #(.DEPTH_BYTES(DEPTH)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .data_i     (data_i),
        .data_o     (data_o),
        .data_width (data_width),
        .data_addr  (data_addr),
        .signext    (signext),
        .input_data (input_data),
        .read       (read)
`ifdef DATA_MEM_ALIGN_CHECK_EN
        ,
        .misalign_err (misalign_err)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %08h want %08h", tag, got, want);
        end
    endtask

    // Reference load: assemble bytes arithmetically, then extend
    function automatic logic [31:0] mdl_load(input int w, input logic [31:0] addr, input bit sx);
        int a;
        longint v;
        a = int'(addr % DEPTH);
        case (w)
            0: begin
                v = mdl[a];
                if (sx && v >= 128) v = v - 256;
            end
            1: begin
                v = mdl[a] + 256 * mdl[(a + 1) % DEPTH];
                if (sx && v >= 32768) v = v - 65536;
            end
            2: v = longint'(mdl[a]) + 256 * longint'(mdl[(a + 1) % DEPTH])
                   + 65536 * longint'(mdl[(a + 2) % DEPTH])
                   + 16777216 * longint'(mdl[(a + 3) % DEPTH]);
            default: v = 0;
        endcase
        return v[31:0];
    endfunction

    task automatic mdl_store(input int w, input logic [31:0] addr, input logic [31:0] din);
        int a;
        int n;
        a = int'(addr % DEPTH);
        n = (w == 0) ? 1 : (w == 1) ? 2 : (w == 2) ? 4 : 0;
        for (int k = 0; k < n; k++) begin
            mdl[(a + k) % DEPTH] = 8'((din >> (8 * k)) & 32'hFF);
        end
    endtask

    // One clock: drive, clock, advance the model, settle to sample point
    task automatic step(input bit rst, input bit we, input bit re, input int w,
                        input logic [31:0] addr, input bit sx, input logic [31:0] din);
        RST = rst;
        data_i = we;
        data_o = re;
        data_width = 2'(w);
        data_addr = addr;
        signext = sx;
        input_data = din;
        @(posedge CLK);
        if (rst) begin
            exp_read = '0;
        end else begin
            if (re) exp_read = mdl_load(w, addr, sx);
            if (we) mdl_store(w, addr, din);
        end
        #1;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mdl[i] = 8'h00;

        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        check("reset_read", read, 32'h0);

        // Known contents everywhere so the model never depends on power-up state
        for (int i = 0; i < DEPTH; i += 4) step(0, 1, 0, 2, i, 0, 0);
        check("idle_hold_zero", read, 32'h0);

        step(0, 1, 0, 0, 5, 0, 32'h2);
        step(0, 0, 1, 0, 5, 0, 0);
        check("lbu_basic", read, 32'h0000_0002);

        step(0, 1, 0, 0, 32'h10, 0, 32'h80);
        step(0, 0, 1, 0, 32'h10, 1, 0);
        check("lb_sign", read, 32'hFFFF_FF80);
        step(0, 0, 1, 0, 32'h10, 0, 0);
        check("lbu_zero", read, 32'h0000_0080);

        step(0, 1, 0, 2, 32'h20, 0, 32'h1234_8765);
        step(0, 0, 1, 1, 32'h20, 1, 0);
        check("lh_sign", read, 32'hFFFF_8765);
        step(0, 0, 1, 1, 32'h22, 0, 0);
        check("lhu_hi", read, 32'h0000_1234);
        step(0, 0, 1, 0, 32'h23, 1, 0);
        check("lb_top", read, 32'h0000_0012);
        step(0, 0, 1, 2, 32'h21, 0, 0);
        check("lw_unaligned", read, 32'h0012_3487);
        step(0, 0, 1, 2, 32'h8000_0020, 0, 0);
        check("lw_addr_hi_ignored", read, 32'h1234_8765);

        step(0, 1, 0, 2, 32'h40, 0, 32'hAABB_CCDD);
        step(0, 1, 0, 0, 32'h41, 0, 32'h11);
        step(0, 0, 1, 2, 32'h40, 0, 0);
        check("partial_store", read, 32'hAABB_11DD);

        step(0, 1, 1, 2, 32'h40, 0, 32'h0);
        check("read_before_write", read, 32'hAABB_11DD);
        step(0, 0, 1, 2, 32'h40, 0, 0);
        check("after_write", read, 32'h0);
        step(0, 0, 1, 2, 32'h20, 0, 0);
        step(0, 1, 0, 0, 32'h60, 0, 32'h5A);
        check("hold_no_load", read, 32'h1234_8765);

        step(1, 1, 1, 2, 32'h20, 0, 32'hFFFF_FFFF);
        check("reset_during_load", read, 32'h0);
        step(0, 0, 1, 2, 32'h20, 0, 0);
        check("reset_blocks_store", read, 32'h1234_8765);

        step(0, 1, 0, 3, 32'h20, 0, 32'hDEAD_BEEF);
        step(0, 0, 1, 2, 32'h20, 0, 0);
        check("rsvd_store_suppressed", read, 32'h1234_8765);
        step(0, 0, 1, 3, 32'h20, 1, 0);
        check("rsvd_load_zero", read, 32'h0);

        step(0, 1, 0, 2, DEPTH - 2, 0, 32'h0BAD_F00D);
        step(0, 0, 1, 2, 0, 0, 0);
        check("wrap_low_bytes", read, 32'h0000_0BAD);
        step(0, 0, 1, 2, DEPTH - 2, 0, 0);
        check("wrap_word", read, 32'h0BAD_F00D);
        step(0, 0, 1, 1, DEPTH - 1, 1, 0);
        check("wrap_half_sign", read, 32'hFFFF_ADF0);

        // Random traffic, biased toward the top of memory for wrap coverage
        for (int n = 0; n < 3000; n++) begin
            bit          r_rst;
            bit          r_we;
            bit          r_re;
            int          r_w;
            logic [31:0] r_addr;
            r_rst = ($urandom_range(0, 49) == 0);
            r_we = $urandom_range(0, 1) == 1;
            r_re = $urandom_range(0, 2) != 0;
            r_w = int'($urandom_range(0, 3));
            r_addr = $urandom();
            if ($urandom_range(0, 3) == 0) r_addr[9:0] = 10'(DEPTH - 1 - $urandom_range(0, 3));
            step(r_rst, r_we, r_re, r_w, r_addr, 1'($urandom_range(0, 1)), $urandom());
            check("random", read, exp_read);
        end

        data_i = 1'b0;
        data_o = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
